fetch_ctrl: RTL
===============

# fetch_ctrl

Sequencing controller for the instruction-fetch stage. It owns the program counter and drives a valid/ready request port plus a valid response port on instruction memory, so memory latency may vary. It presents one fetched instruction at a time to decode and handles hazard-unit stalls and execute-stage redirects. It keeps at most one memory request outstanding and discards responses for squashed requests.

## Interface
- ADDRESS_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- stall_f  in  1  decode cannot accept; hold the output slot
- pc_src_e  in  1  redirect request from execute
- pc_target_e  in  ADDRESS_WIDTH  redirect target
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  ADDRESS_WIDTH  request address
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  DATA_WIDTH  fetched instruction
- pc_f  out  ADDRESS_WIDTH  PC of the instruction in the slot
- pc_plus4_f  out  ADDRESS_WIDTH  pc_f + 4
- instr_f  out  DATA_WIDTH  instruction in the slot
- instr_valid_f  out  1  the slot holds an unconsumed instruction

## Operation
- Internal state: fetch PC register `pc_q`, a one-entry output slot (instr_f, pc_f, instr_valid_f), and an FSM with states REQ, WAIT and DROP.
- **Consume rule:** the slot is consumed in any cycle where instr_valid_f=1 and stall_f=0.
- **REQ state**
  - imem_req_valid=1 and imem_req_addr=pc_q.
  - A request may issue only if the slot is empty or is being consumed this cycle. Otherwise imem_req_valid=0 and the FSM stays in REQ.
  - Handshake occurs when imem_req_valid=1 and imem_req_ready=1; the FSM then moves to WAIT.
  - While valid=1 and ready=0, imem_req_addr stays stable. The only exception is a redirect.
- **WAIT state**
  - imem_req_valid=0.
  - On imem_rsp_valid=1, the slot loads instr_f=imem_rsp_data and pc_f=pc_q, and sets instr_valid_f=1.
  - In the same cycle, pc_q←pc_q+4 and the FSM moves to REQ.
- **DROP state**
  - imem_req_valid=0.
  - On imem_rsp_valid=1, the response is discarded, the slot is left unchanged, and the FSM moves to REQ.
- **Redirect** (pc_src_e=1) has priority over stall and over every state:
  - pc_q←pc_target_e and instr_valid_f←0 (slot flushed).
  - If a request is outstanding (state WAIT, or a REQ handshake in this same cycle), the next state is DROP.
  - If a response arrives in that same cycle, it is discarded.
  - In REQ without a handshake, the next state is REQ, with imem_req_addr=pc_target_e from the next cycle.
  - A redirect while in DROP keeps DROP and updates pc_q.
- **Width:** pc_q+4 and pc_plus4_f wrap modulo 2^ADDRESS_WIDTH. Addresses are not alignment-checked.
- imem_rsp_valid outside WAIT and DROP is ignored.

## Timing
- Reset (rst=0, asynchronous): FSM=REQ, pc_q=RESET_PC, instr_valid_f=0, instr_f=0, pc_f=0, pc_plus4_f=4, imem_req_valid=0.
- First request (imem_req_valid=1, imem_req_addr=RESET_PC) appears in the first cycle after rst deasserts.
- The earliest response is the cycle after the request handshake. instr_valid_f rises the cycle after the response.
- Peak throughput is one instruction per 2 cycles: REQ then WAIT, with ready=1 and a 1-cycle response.
- Stall: the slot holds its values while stall_f=1. The next request issues in the cycle the slot is consumed.
- Redirect: instr_valid_f=0 in the cycle after pc_src_e. With no request outstanding, the target request issues that same next cycle.
- Reset mid-operation (e.g., in WAIT): the state is abandoned immediately and the next post-reset response is ignored, because the FSM is in REQ.

## Test plan
- **Reset:** hold rst=0 for 3 cycles and drive imem_rsp_valid=1 → all outputs hold their reset values. On release, imem_req_addr=0x0 and imem_req_valid=1 in the first cycle.
- **Streaming:** ready=1, response latency 1, memory returns addr^0xA5A5 → instr_valid_f pulses every 2 cycles with pc_f=0x0,0x4,0x8 and instr_f matching; pc_plus4_f=pc_f+4.
- **Stall:** stall_f=1 for 5 cycles while the slot holds pc_f=0x4 → slot stable and imem_req_valid=0. The request for 0x8 issues in the cycle stall_f drops.
- **Backpressure:** imem_req_ready=0 for 4 cycles → imem_req_valid=1 with addr stable at 0x8 throughout; WAIT is entered only on ready.
- **Redirect in WAIT:** pc_src_e=1, target=0x100, during WAIT for 0xC → the 0xC response is discarded and never appears on instr_f. The next request is 0x100, and pc_f=0x100 at the next instr_valid_f.
- **Wrap:** RESET_PC=0xFFFFFFFC → first pc_f=0xFFFFFFFC, pc_plus4_f=0x0, and the next request address is 0x0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight, feeds a one-entry decode slot.
// Request valid is combinational from state, slot occupancy and stall; PC, slot and FSM are registered.
module fetch_ctrl #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_f,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     imem_req_valid,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic                     instr_valid_f
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_pc_q;
  logic [ADDRESS_WIDTH-1:0] r_pc_f;
  logic [DATA_WIDTH-1:0]    r_instr_f;
  logic                     r_instr_vld;
  logic                     r_run;

  logic w_consume;
  logic w_req_vld;
  logic w_hs;
  logic w_in_flight;

  assign w_consume   = r_instr_vld & ~stall_f;
  // r_run keeps the request port quiet for the reset cycle itself.
  assign w_req_vld   = r_run & (r_state == S_REQ) & (~r_instr_vld | ~stall_f);
  assign w_hs        = w_req_vld & imem_req_ready;
  assign w_in_flight = (r_state != S_REQ) & ~imem_rsp_valid;

  assign imem_req_valid = w_req_vld;
  assign imem_req_addr  = r_pc_q;
  assign pc_f           = r_pc_f;
  assign pc_plus4_f     = r_pc_f + ADDRESS_WIDTH'(4);
  assign instr_f        = r_instr_f;
  assign instr_valid_f  = r_instr_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_REQ;
      r_pc_q      <= RESET_PC;
      r_pc_f      <= '0;
      r_instr_f   <= '0;
      r_instr_vld <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (pc_src_e) begin
        // A request still owed a response must have that response swallowed.
        r_pc_q      <= pc_target_e;
        r_instr_vld <= 1'b0;
        if (w_hs || w_in_flight) begin
          r_state <= S_DROP;
        end else begin
          r_state <= S_REQ;
        end
      end else begin
        if (w_consume) begin
          r_instr_vld <= 1'b0;
        end
        case (r_state)
          S_REQ: begin
            if (w_hs) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              r_instr_f   <= imem_rsp_data;
              r_pc_f      <= r_pc_q;
              r_instr_vld <= 1'b1;
              r_pc_q      <= r_pc_q + ADDRESS_WIDTH'(4);
              r_state     <= S_REQ;
            end
          end
          S_DROP: begin
            if (imem_rsp_valid) begin
              r_state <= S_REQ;
            end
          end
          default: r_state <= S_REQ;
        endcase
      end
    end
  end

endmodule
